// File: rtl/piggy_pkg.sv
// rtl/piggy_pkg.sv - shared types and coin denominations for the piggy coin bank
// Contents: state_t FSM encoding, COIN_V0..COIN_V3 values, coin_value() lookup.
package piggy_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PAYOUT = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] COIN_V0 = 4'd1;
  localparam logic [3:0] COIN_V1 = 4'd2;
  localparam logic [3:0] COIN_V2 = 4'd5;
  localparam logic [3:0] COIN_V3 = 4'd10;

  function automatic logic [3:0] coin_value(input logic [1:0] sel);
    case (sel)
      2'd0:    return COIN_V0;
      2'd1:    return COIN_V1;
      2'd2:    return COIN_V2;
      default: return COIN_V3;
    endcase
  endfunction

endpackage

// File: rtl/piggy_coin_bank_if.sv
// rtl/piggy_coin_bank_if.sv - coin/withdraw inputs and bank status outputs bundle
// master drives coin_lvl, coin_sel, withdraw and observes the bank outputs;
// slave (the bank) consumes the inputs and drives balance, goal_reached,
// coin_ack, coin_reject, pay_pulse, pay_done, busy.
interface piggy_coin_bank_if #(
  parameter int BAL_W = 8
);
  logic             coin_lvl;
  logic [1:0]       coin_sel;
  logic             withdraw;
  logic [BAL_W-1:0] balance;
  logic             goal_reached;
  logic             coin_ack;
  logic             coin_reject;
  logic             pay_pulse;
  logic             pay_done;
  logic             busy;

  modport master (
    output coin_lvl, coin_sel, withdraw,
    input  balance, goal_reached, coin_ack, coin_reject, pay_pulse, pay_done, busy
  );

  modport slave (
    input  coin_lvl, coin_sel, withdraw,
    output balance, goal_reached, coin_ack, coin_reject, pay_pulse, pay_done, busy
  );
endinterface

// File: rtl/piggy_edge_det.sv
// rtl/piggy_edge_det.sv - registered rising-edge detector
// Ports: clk, rst_n (async active-low), lvl_i (synchronous level),
//        rise_o (one-cycle pulse, registered on the edge that sees the rise).
module piggy_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic lvl_i,
  output logic rise_o
);
  logic prev_q;
  logic rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= lvl_i;
      rise_q <= lvl_i & ~prev_q;
    end
  end

  assign rise_o = rise_q;
endmodule

// File: rtl/piggy_coin_bank.sv
// rtl/piggy_coin_bank.sv - coin crediting bank with goal flag and paced payout
// Ports: clk, rst_n (async active-low), bus (piggy_coin_bank_if.slave):
//   coin_lvl/coin_sel/withdraw in; balance, goal_reached, coin_ack,
//   coin_reject, pay_pulse, pay_done, busy out (all registered).
// Optional: define PIGGY_LOCK_EN to honour withdraw only once the goal is reached.
module piggy_coin_bank
  import piggy_pkg::*;
#(
  parameter int BAL_W   = 8,
  parameter int GOAL    = 50,
  parameter int PAY_GAP = 4
) (
  input logic             clk,
  input logic             rst_n,
  piggy_coin_bank_if.slave bus
);
  localparam int CNT_W = (PAY_GAP > 2) ? $clog2(PAY_GAP) : 1;
  localparam logic [CNT_W-1:0] GAP_RELOAD = CNT_W'(PAY_GAP - 1);

  logic             coin_rise;
  logic             wd_rise;
  logic [1:0]       sel_q;
  state_t           state_q;
  logic [CNT_W-1:0] gap_q;
  logic [BAL_W-1:0] bal_q;
  logic [BAL_W-1:0] bal_d;
  logic             goal_q;
  logic             ack_q;
  logic             rej_q;
  logic             pay_q;
  logic             done_q;
  logic             busy_q;
  logic [BAL_W:0]   sum;
  logic             coin_fits;
  logic             wd_go;
  logic             pay_now;

  piggy_edge_det u_coin_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .lvl_i  (bus.coin_lvl),
    .rise_o (coin_rise)
  );

  piggy_edge_det u_wd_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .lvl_i  (bus.withdraw),
    .rise_o (wd_rise)
  );

  always_comb begin
    // One extra bit: the carry out is exactly the overflow condition.
    sum       = {1'b0, bal_q} + (BAL_W+1)'(coin_value(sel_q));
    coin_fits = ~sum[BAL_W];
    // A coin arriving together with a withdraw wins; the withdraw is dropped.
`ifdef PIGGY_LOCK_EN
    wd_go     = wd_rise & ~coin_rise & (bal_q != '0) & goal_q;
`else
    wd_go     = wd_rise & ~coin_rise & (bal_q != '0);
`endif
    pay_now   = (state_q == PAYOUT) && (gap_q == '0);
    bal_d     = bal_q;
    if ((state_q == IDLE) && coin_rise && coin_fits) begin
      bal_d = sum[BAL_W-1:0];
    end else if (pay_now) begin
      bal_d = bal_q - BAL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      gap_q   <= '0;
      bal_q   <= '0;
      goal_q  <= 1'b0;
      ack_q   <= 1'b0;
      rej_q   <= 1'b0;
      pay_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // coin_sel captured on the same edge as the coin rise, used one edge later.
      sel_q  <= bus.coin_sel;
      bal_q  <= bal_d;
      goal_q <= (bal_d >= BAL_W'(GOAL));
      ack_q  <= 1'b0;
      rej_q  <= 1'b0;
      pay_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (coin_rise) begin
            ack_q <= coin_fits;
            rej_q <= ~coin_fits;
          end
          if (wd_go) begin
            state_q <= PAYOUT;
            gap_q   <= GAP_RELOAD;
            busy_q  <= 1'b1;
          end
        end
        PAYOUT: begin
          rej_q <= coin_rise;
          if (pay_now) begin
            pay_q <= 1'b1;
            gap_q <= GAP_RELOAD;
            if (bal_q == BAL_W'(1)) begin
              state_q <= DONE;
            end
          end else begin
            gap_q <= gap_q - CNT_W'(1);
          end
        end
        DONE: begin
          rej_q   <= coin_rise;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.balance      = bal_q;
  assign bus.goal_reached = goal_q;
  assign bus.coin_ack     = ack_q;
  assign bus.coin_reject  = rej_q;
  assign bus.pay_pulse    = pay_q;
  assign bus.pay_done     = done_q;
  assign bus.busy         = busy_q;
endmodule
